// File: rtl/pipeline_decode.sv
// pipeline_decode: RV32I decode stage.
// IF/ID capture, combinational decode, 32-entry register file, load-use
// hazard detection and the ID/EX register feeding EX.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a register read
// whose index matches the same-cycle WB write returns the WB data.
module pipeline_decode #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic [31:0]     instruction_i,
    input  logic [31:0]     pc_i,
    input  logic [31:0]     pcsrc_i,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [31:0]     pc_o,
    output logic [31:0]     pcsrc_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [31:0]     imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic            funct7b5_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            alu_src_o,
    output logic            illegal_o
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    logic [31:0]     ifid_instr;
    logic [31:0]     ifid_pc;
    logic [31:0]     ifid_pcsrc;
    logic            ifid_valid;

    logic [XLEN-1:0] regs [NREGS];

    opcode_e         opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic            illegal;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            stall;
    logic            bubble;

    assign rs1     = ifid_instr[19:15];
    assign rs2     = ifid_instr[24:20];
    assign stall_o = stall;
    assign bubble  = flush_i || stall || !ifid_valid;

    // IF/ID register: flush kills the entry, stall holds it, otherwise load from fetch
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_pcsrc <= '0;
            ifid_valid <= 1'b0;
        end else if (flush_i) begin
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_instr <= instruction_i;
            ifid_pc    <= pc_i;
            ifid_pcsrc <= pcsrc_i;
            ifid_valid <= valid_i;
        end
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    // Register file read ports with x0 forced to zero and optional WB bypass
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
        if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1)) rs1_val = wb_data_i;
        if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2)) rs2_val = wb_data_i;
`endif
    end

    // Instruction decode: control bits, immediate and source usage from the IF/ID opcode
    always_comb begin
        opcode    = opcode_e'(ifid_instr[6:0]);
        rd        = ifid_instr[11:7];
        imm       = '0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alu_src   = 1'b0;
        illegal   = 1'b0;
        use_rs1   = 1'b1;
        use_rs2   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm       = {ifid_instr[31:12], 12'b0};
                reg_write = 1'b1;
                alu_src   = 1'b1;
                use_rs1   = 1'b0;
            end
            OP_JAL: begin
                imm       = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                             ifid_instr[20], ifid_instr[30:21], 1'b0};
                reg_write = 1'b1;
                jump      = 1'b1;
                use_rs1   = 1'b0;
            end
            OP_JALR: begin
                imm       = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
                reg_write = 1'b1;
                jump      = 1'b1;
                alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                imm       = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                             ifid_instr[30:25], ifid_instr[11:8], 1'b0};
                rd        = 5'd0;
                branch    = 1'b1;
                use_rs2   = 1'b1;
            end
            OP_LOAD: begin
                imm       = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
                reg_write = 1'b1;
                mem_read  = 1'b1;
                alu_src   = 1'b1;
            end
            OP_STORE: begin
                imm       = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
                rd        = 5'd0;
                mem_write = 1'b1;
                alu_src   = 1'b1;
                use_rs2   = 1'b1;
            end
            OP_IMM: begin
                imm       = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_REG: begin
                reg_write = 1'b1;
                use_rs2   = 1'b1;
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
        if (rd == 5'd0) reg_write = 1'b0;
    end

    // Load-use hazard: a load in ID/EX targets a register the IF/ID instruction reads
    always_comb begin
        stall = ifid_valid && valid_o && mem_read_o && (rd_o != 5'd0) &&
                ((use_rs1 && (rs1 == rd_o)) || (use_rs2 && (rs2 == rd_o)));
    end

    // ID/EX register: decoded entry on a normal cycle, all-zero bubble otherwise
    always_ff @(posedge clk_i) begin
        if (!reset_ni || bubble) begin
            valid_o     <= 1'b0;
            pc_o        <= '0;
            pcsrc_o     <= '0;
            rs1_data_o  <= '0;
            rs2_data_o  <= '0;
            imm_o       <= '0;
            rs1_o       <= '0;
            rs2_o       <= '0;
            rd_o        <= '0;
            funct3_o    <= '0;
            funct7b5_o  <= 1'b0;
            reg_write_o <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            branch_o    <= 1'b0;
            jump_o      <= 1'b0;
            alu_src_o   <= 1'b0;
            illegal_o   <= 1'b0;
        end else begin
            valid_o     <= 1'b1;
            pc_o        <= ifid_pc;
            pcsrc_o     <= ifid_pcsrc;
            rs1_data_o  <= rs1_val;
            rs2_data_o  <= rs2_val;
            imm_o       <= imm;
            rs1_o       <= rs1;
            rs2_o       <= rs2;
            rd_o        <= rd;
            funct3_o    <= ifid_instr[14:12];
            funct7b5_o  <= ifid_instr[30];
            reg_write_o <= reg_write;
            mem_read_o  <= mem_read;
            mem_write_o <= mem_write;
            branch_o    <= branch;
            jump_o      <= jump;
            alu_src_o   <= alu_src;
            illegal_o   <= illegal;
        end
    end

endmodule
